hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage CPU: drives write-enable, flush and bubble controls for the PC, the IF/ID pipeline register, ID/EX and EX/MEM.
- Detects load-use hazards, taken branches (resolved in MEM), instruction-memory wait and halt.
- Runs a small FSM for multi-cycle stalls.
- Keeps saturating stall and flush counters for debug and performance measurement.

Parameters:
- LOAD_LAT, 1: stall cycles inserted per load-use hazard (legal 1..7).
- CNT_W, 16: width of the performance counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- ifid_rs_i  in  5  rs field of the instruction in IF/ID.
- ifid_rt_i  in  5  rt field of the instruction in IF/ID.
- ifid_uses_rt_i  in  1  IF/ID instruction reads rt.
- idex_memread_i  in  1  ID/EX instruction is a load.
- idex_rt_i  in  5  destination rt of the ID/EX load.
- branch_taken_i  in  1  MEM-stage branch/jump taken.
- halt_i  in  1  ID stage decodes a halt instruction.
- imem_ready_i  in  1  instruction memory has valid data this cycle.
- pc_write_o  out  1  PC load enable.
- ifid_write_o  out  1  IF/ID load enable.
- ifid_flush_o  out  1  IF/ID loads a NOP (all zeros).
- idex_bubble_o  out  1  ID/EX loads control zeros.
- exmem_flush_o  out  1  EX/MEM loads control zeros.
- state_o  out  2  FSM state: RUN=0, LU_STALL=1, IMEM_WAIT=2, HALTED=3.
- stall_cnt_o  out  CNT_W  cycles with pc_write_o=0, excluding HALTED.
- flush_cnt_o  out  CNT_W  number of branch flushes.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high; it is sampled at the clk_i rising edge.
- While rst_i=1, outputs are forced to: pc_write_o=0, ifid_write_o=0, ifid_flush_o=1, idex_bubble_o=1, exmem_flush_o=0. A registered rst_i=1 takes the state to RUN and clears both counters and the stall counter. Reset mid-stall aborts the stall.
- Control outputs are combinational from the current state and inputs (Mealy). State and counters are registered.
- Load-use hazard: lu = idex_memread_i & (idex_rt_i!=0) & ((idex_rt_i==ifid_rs_i) | (ifid_uses_rt_i & idex_rt_i==ifid_rt_i)).
- Event priority each cycle: branch > halt > load-use > imem wait.
- Branch, any non-HALTED state:
  - Outputs: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, exmem_flush=1.
  - Next state RUN; stall count cleared; flush_cnt increments.
- Halt (no branch):
  - Outputs: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1.
  - Next state HALTED.
  - HALTED holds the same outputs every cycle, ignores all inputs including branch_taken_i, and is left only by reset.
- RUN, lu=1:
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
  - LOAD_LAT=1: stay in RUN.
  - LOAD_LAT>1: go to LU_STALL with remaining = LOAD_LAT-1.
- LU_STALL:
  - Same stall outputs as a RUN load-use cycle; the lu input is ignored.
  - remaining decrements each cycle.
  - When remaining==1, next state is RUN if imem_ready_i=1, else IMEM_WAIT.
- RUN, imem_ready_i=0 (no higher-priority event):
  - Outputs: pc_write=0, ifid_write=1, ifid_flush=1 (a bubble enters IF/ID), idex_bubble=0.
  - Next state IMEM_WAIT.
- IMEM_WAIT:
  - Same outputs as above while imem_ready_i=0.
  - When imem_ready_i=1: normal RUN outputs this cycle, next state RUN.
  - lu=1 in IMEM_WAIT: lu stall outputs apply and LU_STALL entry rules as in RUN.
- RUN, no event: pc_write=1, ifid_write=1, all flush/bubble outputs 0.
- Any control output not listed for a case is 0.
- Counters saturate at 2^CNT_W-1 and never wrap.
- stall_cnt increments on every non-reset, non-HALTED cycle with pc_write_o=0.

Test Plan:
- Load-use: lw $2 in ID/EX (idex_memread=1, idex_rt=2), IF/ID rs=2, LOAD_LAT=1 -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1; next cycle RUN; stall_cnt=1.
- No hazard on $0: idex_rt=0 matching rs=0 -> no stall. Same check with ifid_uses_rt=0 and an rt match -> no stall.
- LOAD_LAT=3: hazard -> 3 consecutive stall cycles with state_o sequence 0,1,1 then 0. Branch asserted in the second stall cycle -> stall aborted, all flushes=1, flush_cnt=1, RUN.
- imem_ready_i low for 4 cycles -> state 2, ifid_flush=1, pc_write=0 for 4 cycles; stall_cnt=4; ready=1 -> RUN with pc_write=1.
- halt_i and branch_taken_i in the same cycle -> branch wins, RUN. halt_i alone -> HALTED permanently; a later branch_taken_i is ignored; rst_i=1 for one cycle -> RUN, counters 0.
- CNT_W=4, imem_ready_i held low 20 cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing for the 5-stage core.
// Generates PC / IF/ID / ID/EX / EX/MEM load, flush and bubble controls from
// load-use, taken-branch, imem-wait and halt events. It also keeps saturating
// stall and flush counters for debug and performance measurement.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   RUN          | normal issue; events are evaluated every cycle
//   LU_STALL     | extra load-use stall cycles (LOAD_LAT > 1), lu ignored
//   IMEM_WAIT    | waiting for instruction memory, bubbles enter IF/ID
//   HALTED       | halt decoded; frozen until reset, branches ignored
module hazard_ctrl #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic             branch_taken_i,
    input  logic             halt_i,
    input  logic             imem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_flush_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_LU_STALL  = 2'd1,
        ST_IMEM_WAIT = 2'd2,
        ST_HALTED    = 2'd3
    } state_t;

    // Stall cycles still owed after the first load-use cycle.
    localparam logic [2:0] LU_EXTRA = 3'(LOAD_LAT - 1);

    state_t           state_q, state_d;
    logic [2:0]       remain_q, remain_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             lu;
    logic             stall_inc;
    logic             flush_inc;

    assign lu = idex_memread_i && (idex_rt_i != 5'd0) &&
                ((idex_rt_i == ifid_rs_i) ||
                 (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

    // Mealy control outputs: priority reset > halted > branch > halt > load-use > imem wait.
    always_comb begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        exmem_flush_o = 1'b0;
        if (rst_i) begin
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end else if (state_q == ST_HALTED) begin
            idex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            pc_write_o    = 1'b1;
            ifid_write_o  = 1'b1;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            exmem_flush_o = 1'b1;
        end else if (halt_i || (state_q == ST_LU_STALL) || lu) begin
            idex_bubble_o = 1'b1;
        end else if (!imem_ready_i) begin
            ifid_write_o  = 1'b1;
            ifid_flush_o  = 1'b1;
        end else begin
            pc_write_o    = 1'b1;
            ifid_write_o  = 1'b1;
        end
    end

    // Next-state and stall-remaining selection, same event priority as the outputs.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        if (state_q != ST_HALTED) begin
            if (branch_taken_i) begin
                state_d  = ST_RUN;
                remain_d = 3'd0;
            end else if (halt_i) begin
                state_d  = ST_HALTED;
                remain_d = 3'd0;
            end else if (state_q == ST_LU_STALL) begin
                remain_d = remain_q - 3'd1;
                if (remain_q == 3'd1) begin
                    state_d = imem_ready_i ? ST_RUN : ST_IMEM_WAIT;
                end
            end else if (lu) begin
                if (LOAD_LAT > 1) begin
                    state_d  = ST_LU_STALL;
                    remain_d = LU_EXTRA;
                end else begin
                    // Single-cycle stall: an outstanding imem wait is kept.
                    state_d = ((state_q == ST_IMEM_WAIT) && !imem_ready_i) ?
                              ST_IMEM_WAIT : ST_RUN;
                end
            end else if (!imem_ready_i) begin
                state_d = ST_IMEM_WAIT;
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    assign stall_inc = (state_q != ST_HALTED) && !pc_write_o;
    assign flush_inc = (state_q != ST_HALTED) && branch_taken_i;

    // State, stall-remaining and saturating performance counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            remain_q    <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances share one stimulus stream
// (LOAD_LAT=1, LOAD_LAT=3, and LOAD_LAT=1 with 4-bit counters) and are
// compared against an event-level reference model every cycle.
module tb_hazard_ctrl;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic       rst_i          = 1'b1;
    logic [4:0] ifid_rs_i      = '0;
    logic [4:0] ifid_rt_i      = '0;
    logic       ifid_uses_rt_i = 1'b0;
    logic       idex_memread_i = 1'b0;
    logic [4:0] idex_rt_i      = '0;
    logic       branch_taken_i = 1'b0;
    logic       halt_i         = 1'b0;
    logic       imem_ready_i   = 1'b1;

    logic        pw [3];
    logic        iw [3];
    logic        ifl[3];
    logic        ib [3];
    logic        ef [3];
    logic [1:0]  st [3];
    logic [15:0] sc0, sc1, fc0, fc1;
    logic [3:0]  sc2, fc2;

    hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) u_l1 (
        .clk_i(clk_i), .rst_i(rst_i), .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
        .ifid_uses_rt_i(ifid_uses_rt_i), .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
        .branch_taken_i(branch_taken_i), .halt_i(halt_i), .imem_ready_i(imem_ready_i),
        .pc_write_o(pw[0]), .ifid_write_o(iw[0]), .ifid_flush_o(ifl[0]), .idex_bubble_o(ib[0]),
        .exmem_flush_o(ef[0]), .state_o(st[0]), .stall_cnt_o(sc0), .flush_cnt_o(fc0));

    hazard_ctrl #(.LOAD_LAT(3), .CNT_W(16)) u_l3 (
        .clk_i(clk_i), .rst_i(rst_i), .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
        .ifid_uses_rt_i(ifid_uses_rt_i), .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
        .branch_taken_i(branch_taken_i), .halt_i(halt_i), .imem_ready_i(imem_ready_i),
        .pc_write_o(pw[1]), .ifid_write_o(iw[1]), .ifid_flush_o(ifl[1]), .idex_bubble_o(ib[1]),
        .exmem_flush_o(ef[1]), .state_o(st[1]), .stall_cnt_o(sc1), .flush_cnt_o(fc1));

    hazard_ctrl #(.LOAD_LAT(1), .CNT_W(4)) u_c4 (
        .clk_i(clk_i), .rst_i(rst_i), .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
        .ifid_uses_rt_i(ifid_uses_rt_i), .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
        .branch_taken_i(branch_taken_i), .halt_i(halt_i), .imem_ready_i(imem_ready_i),
        .pc_write_o(pw[2]), .ifid_write_o(iw[2]), .ifid_flush_o(ifl[2]), .idex_bubble_o(ib[2]),
        .exmem_flush_o(ef[2]), .state_o(st[2]), .stall_cnt_o(sc2), .flush_cnt_o(fc2));

    int total  = 0;
    int passed = 0;

    // Reference model: per-instance flags and counts.
    int lat [3] = '{1, 3, 1};
    int cmax[3] = '{65535, 65535, 15};
    bit m_halt[3];
    bit m_wait[3];
    int m_left[3];
    int m_stall[3];
    int m_flush[3];

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s u%0d observed=%0h expected=%0h", tag, k, obs, exp);
    endtask

    function automatic bit ref_lu();
        return idex_memread_i && idex_rt_i != 0 &&
               (idex_rt_i == ifid_rs_i || (ifid_uses_rt_i && idex_rt_i == ifid_rt_i));
    endfunction

    // Expected {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush}.
    function automatic logic [4:0] ref_ctrl(int k);
        if (rst_i)                            return 5'b00110;
        if (m_halt[k])                        return 5'b00010;
        if (branch_taken_i)                   return 5'b11111;
        if (halt_i || m_left[k] > 0 || ref_lu()) return 5'b00010;
        if (!imem_ready_i)                    return 5'b01100;
        return 5'b11000;
    endfunction

    function automatic logic [1:0] ref_state(int k);
        if (m_halt[k])     return 2'd3;
        if (m_left[k] > 0) return 2'd1;
        if (m_wait[k])     return 2'd2;
        return 2'd0;
    endfunction

    task automatic check_inst(int k, logic [31:0] sc, logic [31:0] fc);
        logic [4:0] e;
        e = ref_ctrl(k);
        chk("pc_write",    k, 32'(pw[k]),  32'(e[4]));
        chk("ifid_write",  k, 32'(iw[k]),  32'(e[3]));
        chk("ifid_flush",  k, 32'(ifl[k]), 32'(e[2]));
        chk("idex_bubble", k, 32'(ib[k]),  32'(e[1]));
        chk("exmem_flush", k, 32'(ef[k]),  32'(e[0]));
        chk("state",       k, 32'(st[k]),  32'(ref_state(k)));
        chk("stall_cnt",   k, sc, 32'(m_stall[k]));
        chk("flush_cnt",   k, fc, 32'(m_flush[k]));
    endtask

    task automatic update_model(int k);
        logic [4:0] e;
        e = ref_ctrl(k);
        if (rst_i) begin
            m_halt[k] = 0; m_wait[k] = 0; m_left[k] = 0;
            m_stall[k] = 0; m_flush[k] = 0;
        end else if (!m_halt[k]) begin
            if (!e[4] && m_stall[k] < cmax[k]) m_stall[k]++;
            if (branch_taken_i) begin
                if (m_flush[k] < cmax[k]) m_flush[k]++;
                m_left[k] = 0; m_wait[k] = 0;
            end else if (halt_i) begin
                m_halt[k] = 1; m_left[k] = 0; m_wait[k] = 0;
            end else if (m_left[k] > 0) begin
                m_left[k]--;
                m_wait[k] = (m_left[k] == 0) && !imem_ready_i;
            end else if (ref_lu()) begin
                if (lat[k] > 1) begin
                    m_left[k] = lat[k] - 1; m_wait[k] = 0;
                end else begin
                    m_wait[k] = m_wait[k] && !imem_ready_i;
                end
            end else begin
                m_wait[k] = !imem_ready_i;
            end
        end
    endtask

    task automatic step(bit rst, bit br, bit hlt, bit rdy, bit mr,
                        logic [4:0] xrt, logic [4:0] rs, logic [4:0] rt, bit urt);
        @(posedge clk_i);
        #1;
        rst_i = rst; branch_taken_i = br; halt_i = hlt; imem_ready_i = rdy;
        idex_memread_i = mr; idex_rt_i = xrt; ifid_rs_i = rs; ifid_rt_i = rt;
        ifid_uses_rt_i = urt;
        @(negedge clk_i);
        check_inst(0, 32'(sc0), 32'(fc0));
        check_inst(1, 32'(sc1), 32'(fc1));
        check_inst(2, 32'(sc2), 32'(fc2));
        for (int k = 0; k < 3; k++) update_model(k);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    initial begin
        do_reset();
        do_reset();
        idle(1);
        chk("reset_state", 0, 32'(st[0]), 32'd0);

        // lw $2 followed by a reader of $2
        step(0, 0, 0, 1, 1, 5'd2, 5'd2, 5'd7, 1);
        chk("lu_pc_write", 0, 32'(pw[0]), 32'd0);
        idle(1);
        chk("lu_after_stall_cnt", 0, 32'(sc0), 32'd1);
        chk("lu_after_pc_write", 0, 32'(pw[0]), 32'd1);
        chk("lu3_state_mid", 1, 32'(st[1]), 32'd1);
        idle(1);
        chk("lu3_state_last", 1, 32'(st[1]), 32'd1);
        idle(1);
        chk("lu3_state_done", 1, 32'(st[1]), 32'd0);
        chk("lu3_stall_cnt", 1, 32'(sc1), 32'd3);

        // $0 never hazards; rt match ignored when rt is not read
        step(0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 1);
        chk("r0_no_stall", 0, 32'(pw[0]), 32'd1);
        step(0, 0, 0, 1, 1, 5'd5, 5'd1, 5'd5, 0);
        chk("rt_unused_no_stall", 0, 32'(pw[0]), 32'd1);
        step(0, 0, 0, 1, 1, 5'd5, 5'd1, 5'd5, 1);
        chk("rt_used_stall", 0, 32'(pw[0]), 32'd0);
        idle(3);

        // branch in second LOAD_LAT=3 stall cycle aborts the stall
        do_reset();
        step(0, 0, 0, 1, 1, 5'd3, 5'd3, 5'd0, 0);
        step(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        chk("br_abort_exmem_flush", 1, 32'(ef[1]), 32'd1);
        idle(1);
        chk("br_abort_state", 1, 32'(st[1]), 32'd0);
        chk("br_abort_flush_cnt", 1, 32'(fc1), 32'd1);

        // four cycles of imem wait
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
            chk("imem_flush", 0, 32'(ifl[0]), 32'd1);
        end
        step(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        chk("imem_state", 0, 32'(st[0]), 32'd2);
        chk("imem_stall_cnt", 0, 32'(sc0), 32'd4);
        chk("imem_ready_pc_write", 0, 32'(pw[0]), 32'd1);
        idle(1);
        chk("imem_back_run", 0, 32'(st[0]), 32'd0);

        // branch beats halt; halt alone is sticky until reset
        step(0, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        idle(1);
        chk("br_beats_halt", 0, 32'(st[0]), 32'd0);
        step(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        idle(2);
        chk("halted", 0, 32'(st[0]), 32'd3);
        step(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        chk("halted_ignores_br", 0, 32'(pw[0]), 32'd0);
        idle(1);
        chk("halted_still", 0, 32'(st[0]), 32'd3);
        do_reset();
        idle(1);
        chk("unhalt_state", 0, 32'(st[0]), 32'd0);
        chk("unhalt_stall_cnt", 0, 32'(sc0), 32'd0);
        chk("unhalt_flush_cnt", 0, 32'(fc0), 32'd0);

        // 4-bit counter saturation
        do_reset();
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle(1);
        chk("sat_cnt4", 2, 32'(sc2), 32'd15);
        chk("nosat_cnt16", 0, 32'(sc0), 32'd20);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = (m_halt[0] && ($urandom % 4 == 0)) || ($urandom % 80 == 0);
            step(r, $urandom % 10 == 0, $urandom % 40 == 0, $urandom % 4 != 0,
                 $urandom % 2 == 0, 5'($urandom % 4), 5'($urandom % 4),
                 5'($urandom % 4), $urandom % 2 == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
